// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants and address/data types
package regfile_pkg;

  localparam int REG_DW = 32;
  localparam int REG_AW = 5;
  localparam int REG_N  = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

endpackage

// File: rtl/regfile_wdec.sv
// rtl/regfile_wdec.sv - one-hot write decoder; entry 0 never receives a write enable
module regfile_wdec #(
  parameter int AW = 5,
  parameter int N  = 2 ** AW
) (
  input  logic          we,
  input  logic [AW-1:0] wn,
  output logic [N-1:0]  wen
);

  always_comb begin
    wen = '0;
    for (int i = 1; i < N; i++) begin
      wen[i] = we && (wn == AW'(i));
    end
  end

endmodule

// File: rtl/regfile_32x32.sv
// rtl/regfile_32x32.sv - 32x32 register file, two async read ports, one sync write port
// Optional same-cycle write-through forwarding under REGFILE_BYPASS_EN.
module regfile_32x32
  import regfile_pkg::*;
#(
  parameter int DW = REG_DW,
  parameter int AW = REG_AW
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [AW-1:0] Ra,
  input  logic [AW-1:0] Rb,
  output logic [DW-1:0] Qa,
  output logic [DW-1:0] Qb,
  input  logic          We,
  input  logic [AW-1:0] Wn,
  input  logic [DW-1:0] D
);

  localparam int N = 2 ** AW;

  logic [DW-1:0] regs_q [N];
  logic [DW-1:0] regs_d [N];
  logic [N-1:0]  wen;

  regfile_wdec #(
    .AW (AW),
    .N  (N)
  ) u_wdec (
    .we  (We),
    .wn  (Wn),
    .wen (wen)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      regs_d[i] = wen[i] ? D : regs_q[i];
    end
  end

  // Reset wins over a coincident write: the whole array clears on that edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < N; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    Qa = regs_q[Ra];
    Qb = regs_q[Rb];
`ifdef REGFILE_BYPASS_EN
    if (!Rst && We && (Wn != '0) && (Wn == Ra)) Qa = D;
    if (!Rst && We && (Wn != '0) && (Wn == Rb)) Qb = D;
`endif
    if (Ra == '0) Qa = '0;
    if (Rb == '0) Qb = '0;
  end

endmodule

// File: tb/tb_regfile_32x32.sv
// tb/tb_regfile_32x32.sv - randomized self-checking bench for regfile_32x32 against an array model
module tb_regfile_32x32;

  logic        clk;
  logic        rst;
  logic [4:0]  ra, rb, wn;
  logic [31:0] qa, qb, d;
  logic        we;

  logic [31:0] mdl [32];
  int          n_checks;
  int          n_fail;

  regfile_32x32 dut (
    .Clk (clk),
    .Rst (rst),
    .Ra  (ra),
    .Rb  (rb),
    .Qa  (qa),
    .Qb  (qb),
    .We  (we),
    .Wn  (wn),
    .D   (d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected read value from the architectural rules, given the current inputs.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (!rst && we && wn == a) return d;
`endif
    return mdl[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    end else if (we && wn != 5'd0) begin
      mdl[wn] = d;
    end
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] v);
    we = 1'b1; wn = a; d = v;
    tick();
    we = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    rst = 1'b1; we = 1'b0; wn = 5'd0; d = 32'h0; ra = 5'd0; rb = 5'd0;
    tick();
    rst = 1'b0;

    for (int i = 0; i < 32; i += 7) begin
      ra = 5'(i); rb = 5'(31 - i); #1;
      check("reset_qa", qa, 32'h0);
      check("reset_qb", qb, 32'h0);
    end

    write(5'd5, 32'hDEADBEEF);
    ra = 5'd5; #1;
    check("preload_r5", qa, 32'hDEADBEEF);
    rst = 1'b1; we = 1'b1; wn = 5'd5; d = 32'h1234;
    tick();
    rst = 1'b0; we = 1'b0; #1;
    check("reset_flush_r5", qa, 32'h0);

    write(5'd3, 32'hA5A5_0001);
    ra = 5'd3; rb = 5'd3; #1;
    check("basic_qa", qa, 32'hA5A5_0001);
    check("basic_qb", qb, 32'hA5A5_0001);

    we = 1'b1; wn = 5'd0; d = 32'hFFFF_FFFF; ra = 5'd0; #1;
    check("zero_same_cycle", qa, 32'h0);
    tick();
    we = 1'b0; #1;
    check("zero_after", qa, 32'h0);

    write(5'd7, 32'h11);
    we = 1'b1; wn = 5'd7; d = 32'h22; ra = 5'd7; #1;
`ifdef REGFILE_BYPASS_EN
    check("hazard_same_cycle", qa, 32'h22);
`else
    check("hazard_same_cycle", qa, 32'h11);
`endif
    tick();
    we = 1'b0; #1;
    check("hazard_next_cycle", qa, 32'h22);

    we = 1'b0; wn = 5'd9; d = 32'h55; ra = 5'd9;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) wn = 5'bx0x01;
      tick();
    end
    wn = 5'd9; #1;
    check("we_gating_r9", qa, 32'h0);

    for (int i = 1; i < 32; i++) write(5'(i), 32'(i) * 32'h0101_0101);
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i); rb = 5'(31 - i); #1;
      check("sweep_qa", qa, (i == 0) ? 32'h0 : 32'(i) * 32'h0101_0101);
      check("sweep_qb", qb, (i == 31) ? 32'h0 : 32'(31 - i) * 32'h0101_0101);
    end

    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      we  = $urandom_range(0, 1);
      wn  = 5'($urandom_range(0, 31));
      d   = $urandom;
      ra  = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom_range(0, 31));
      rb  = ($urandom_range(0, 7) == 0) ? ra : 5'($urandom_range(0, 31));
      #1;
      check("rand_qa", qa, exp_read(ra));
      check("rand_qb", qb, exp_read(rb));
      tick();
    end
    rst = 1'b0; we = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
